// File: rtl/mainfsm_if.sv
// Control bundle between the multicycle main FSM and the datapath/decoder side.
// master = FSM (samples Op/Funct, drives strobes and selects); slave = consumer.
interface mainfsm_if #(
   parameter int STATE_W = 4
);
   logic [1:0]         Op;
   logic [5:0]         Funct;
   logic               IRWrite;
   logic               AdrSrc;
   logic [1:0]         ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [1:0]         ResultSrc;
   logic               NextPC;
   logic               RegW;
   logic               MemW;
   logic               Branch;
   logic               ALUOp;
   logic [STATE_W-1:0] State;

   modport master (
      input  Op, Funct,
      output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
             NextPC, RegW, MemW, Branch, ALUOp, State
   );

   modport slave (
      output Op, Funct,
      input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
             NextPC, RegW, MemW, Branch, ALUOp, State
   );
endinterface

// File: rtl/mainfsm.sv
// Multicycle ARM control FSM (Moore); FETCH->FETCH takes 2..5 cycles depending on instruction class.
// No backpressure: advances every clock, Op/Funct are only looked at in DECODE and MEMADR.
module mainfsm #(
   parameter int STATE_W = 4
) (
   input  logic      clk,
   input  logic      reset,
   mainfsm_if.master bus
);
   localparam logic [STATE_W-1:0] FETCH  = STATE_W'(0);
   localparam logic [STATE_W-1:0] DECODE = STATE_W'(1);
   localparam logic [STATE_W-1:0] MEMADR = STATE_W'(2);
   localparam logic [STATE_W-1:0] MEMRD  = STATE_W'(3);
   localparam logic [STATE_W-1:0] MEMWB  = STATE_W'(4);
   localparam logic [STATE_W-1:0] MEMWR  = STATE_W'(5);
   localparam logic [STATE_W-1:0] EXECR  = STATE_W'(6);
   localparam logic [STATE_W-1:0] EXECI  = STATE_W'(7);
   localparam logic [STATE_W-1:0] ALUWB  = STATE_W'(8);
   localparam logic [STATE_W-1:0] BRANCH = STATE_W'(9);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] next_state;

   // Only the I bit and the L bit of Funct steer this machine.
   logic unused_funct;
   assign unused_funct = &{1'b0, bus.Funct[4:1]};

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= next_state;
   end

   always_comb begin
      next_state = FETCH;
      case (state)
         FETCH:  next_state = DECODE;
         DECODE: begin
            case (bus.Op)
               2'b00:   next_state = bus.Funct[5] ? EXECI : EXECR;
               2'b01:   next_state = MEMADR;
               2'b10:   next_state = BRANCH;
               default: next_state = FETCH;
            endcase
         end
         MEMADR: next_state = bus.Funct[0] ? MEMRD : MEMWR;
         MEMRD:  next_state = MEMWB;
         EXECR:  next_state = ALUWB;
         EXECI:  next_state = ALUWB;
         default: next_state = FETCH;
      endcase
   end

   // Illegal codes fall through to the all-zero defaults, so no strobe can escape.
   always_comb begin
      bus.IRWrite   = 1'b0;
      bus.AdrSrc    = 1'b0;
      bus.ALUSrcA   = 2'b00;
      bus.ALUSrcB   = 2'b00;
      bus.ResultSrc = 2'b00;
      bus.NextPC    = 1'b0;
      bus.RegW      = 1'b0;
      bus.MemW      = 1'b0;
      bus.Branch    = 1'b0;
      bus.ALUOp     = 1'b0;
      case (state)
         FETCH: begin
            bus.IRWrite   = 1'b1;
            bus.NextPC    = 1'b1;
            bus.ALUSrcA   = 2'b01;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
         end
         DECODE: begin
            bus.ALUSrcA   = 2'b01;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
         end
         MEMADR: bus.ALUSrcB = 2'b01;
         MEMRD:  bus.AdrSrc  = 1'b1;
         MEMWB: begin
            bus.ResultSrc = 2'b01;
            bus.RegW      = 1'b1;
         end
         MEMWR: begin
            bus.AdrSrc = 1'b1;
            bus.MemW   = 1'b1;
         end
         EXECR:  bus.ALUOp = 1'b1;
         EXECI: begin
            bus.ALUSrcB = 2'b01;
            bus.ALUOp   = 1'b1;
         end
         ALUWB:  bus.RegW = 1'b1;
         BRANCH: begin
            bus.ALUSrcA   = 2'b10;
            bus.ALUSrcB   = 2'b01;
            bus.ResultSrc = 2'b10;
            bus.Branch    = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.State = state;
endmodule
